// File: rtl/game_pkg.sv
// ----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the game sequencer, the game logic and the display
// logic: state encodings, default game timing constants, score width and the
// saturating two-digit BCD increment helper.
// ----------------------------------------------------------------------------
package game_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_MISS  = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    localparam int unsigned LIVES_DEF        = 3;
    localparam int unsigned SERVE_FRAMES_DEF = 60;
    localparam int unsigned MISS_FRAMES_DEF  = 63;
    localparam int unsigned SCORE_W          = 8;

    // Two-digit BCD increment that sticks at 99 (tens in [7:4], ones in [3:0])
    function automatic logic [7:0] bcd_sat_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h99) begin
            r = 8'h99;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_score.sv
// ----------------------------------------------------------------------------
// bcd_score
// Registered two-digit saturating BCD score counter.
// Ports:
//   clk25  in   pixel clock, rising edge
//   rst_n  in   synchronous active-low reset (score -> 00)
//   clr    in   load 00 (takes priority over inc)
//   inc    in   add one, saturating at 99
//   score  out  8-bit BCD score, tens in [7:4]
// ----------------------------------------------------------------------------
module bcd_score
    import game_pkg::*;
(
    input  logic               clk25,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               inc,
    output logic [SCORE_W-1:0] score
);

    logic [SCORE_W-1:0] score_q;
    logic [SCORE_W-1:0] score_d;

    // Next score value: clear, saturating increment or hold
    always_comb begin
        score_d = score_q;
        if (clr) begin
            score_d = 8'h00;
        end else if (inc) begin
            score_d = bcd_sat_inc(score_q);
        end else begin
            score_d = score_q;
        end
    end

    // Score register
    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            score_q <= 8'h00;
        end else begin
            score_q <= score_d;
        end
    end

    assign score = score_q;

endmodule

// File: rtl/game_sequencer.sv
// ----------------------------------------------------------------------------
// game_sequencer
// Game flow controller: IDLE -> SERVE -> PLAY -> MISS -> (SERVE | OVER).
// Ports:
//   clk25       in   25 MHz pixel clock, rising edge
//   rst_n       in   synchronous active-low reset
//   frame_tick  in   one-cycle pulse per frame
//   start       in   asynchronous push-button, active-high
//   hit, miss   in   one-cycle pulses from the ball logic
//   run         out  ball-motion enable
//   serve_load  out  one-cycle pulse: ball reloads start position
//   flash       out  miss colour override
//   game_over   out  high in OVER
//   lives       out  remaining lives
//   score       out  two BCD digits, tens in [7:4]
//   speed       out  ball step size 1..3
// All outputs are registered.
// ----------------------------------------------------------------------------
module game_sequencer
    import game_pkg::*;
#(
    parameter int unsigned LIVES        = LIVES_DEF,
    parameter int unsigned SERVE_FRAMES = SERVE_FRAMES_DEF,
    parameter int unsigned MISS_FRAMES  = MISS_FRAMES_DEF
) (
    input  logic               clk25,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               hit,
    input  logic               miss,
    output logic               run,
    output logic               serve_load,
    output logic               flash,
    output logic               game_over,
    output logic [1:0]         lives,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         speed
);

    localparam logic [1:0] LIVES_LOAD = 2'(LIVES);
    localparam logic [5:0] SERVE_LOAD = 6'(SERVE_FRAMES);
    localparam logic [5:0] MISS_LOAD  = 6'(MISS_FRAMES);

    state_e     state_q, state_d;
    logic [1:0] lives_q, lives_d;
    logic [1:0] speed_q, speed_d;
    logic [2:0] hit_cnt_q, hit_cnt_d;
    logic [5:0] frame_cnt_q, frame_cnt_d;
    logic       entry_q, entry_d;
    logic       run_q, run_d;
    logic       serve_load_q, serve_load_d;
    logic       flash_q, flash_d;
    logic       game_over_q, game_over_d;

    logic       start_meta_q, start_sync_q, start_prev_q;
    logic [1:0] sync_vld_q;
    logic       start_rise_s;
    logic       tick_s;
    logic       score_clr_s;
    logic       score_inc_s;

    // The edge detector only arms once the synchronizer holds a real sample,
    // and its history flop resets high, so a button held through reset
    // release is not seen as a press.
    assign start_rise_s = sync_vld_q[1] & start_sync_q & ~start_prev_q;

    // A frame tick landing in the first cycle of a new state is not counted.
    assign tick_s = frame_tick & ~entry_q;

    // Start synchronizer, edge-detector history and all state/output flops
    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            start_meta_q <= 1'b0;
            start_sync_q <= 1'b0;
            start_prev_q <= 1'b1;
            sync_vld_q   <= 2'b00;
            state_q      <= ST_IDLE;
            lives_q      <= 2'd0;
            speed_q      <= 2'd1;
            hit_cnt_q    <= 3'd0;
            frame_cnt_q  <= 6'd0;
            entry_q      <= 1'b0;
            run_q        <= 1'b0;
            serve_load_q <= 1'b0;
            flash_q      <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            start_meta_q <= start;
            start_sync_q <= start_meta_q;
            start_prev_q <= sync_vld_q[1] ? start_sync_q : 1'b1;
            sync_vld_q   <= {sync_vld_q[0], 1'b1};
            state_q      <= state_d;
            lives_q      <= lives_d;
            speed_q      <= speed_d;
            hit_cnt_q    <= hit_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            entry_q      <= entry_d;
            run_q        <= run_d;
            serve_load_q <= serve_load_d;
            flash_q      <= flash_d;
            game_over_q  <= game_over_d;
        end
    end

    // Next state, game counters and score controls
    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        speed_d     = speed_q;
        hit_cnt_d   = hit_cnt_q;
        frame_cnt_d = frame_cnt_q;
        score_clr_s = 1'b0;
        score_inc_s = 1'b0;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_rise_s) begin
                    state_d     = ST_SERVE;
                    lives_d     = LIVES_LOAD;
                    speed_d     = 2'd1;
                    hit_cnt_d   = 3'd0;
                    frame_cnt_d = SERVE_LOAD;
                    score_clr_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            ST_SERVE: begin
                if (tick_s) begin
                    if (frame_cnt_q == 6'd1) begin
                        state_d     = ST_PLAY;
                        frame_cnt_d = 6'd0;
                    end else begin
                        frame_cnt_d = frame_cnt_q - 6'd1;
                    end
                end else begin
                    frame_cnt_d = frame_cnt_q;
                end
            end
            ST_PLAY: begin
                // miss has priority; a coincident hit is dropped
                if (miss) begin
                    state_d     = ST_MISS;
                    lives_d     = (lives_q != 2'd0) ? (lives_q - 2'd1) : 2'd0;
                    frame_cnt_d = MISS_LOAD;
                end else if (hit) begin
                    score_inc_s = 1'b1;
                    hit_cnt_d   = hit_cnt_q + 3'd1;
                    if ((hit_cnt_q == 3'd7) && (speed_q != 2'd3)) begin
                        speed_d = speed_q + 2'd1;
                    end else begin
                        speed_d = speed_q;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_MISS: begin
                if (tick_s) begin
                    if (frame_cnt_q == 6'd1) begin
                        if (lives_q == 2'd0) begin
                            state_d     = ST_OVER;
                            frame_cnt_d = 6'd0;
                        end else begin
                            state_d     = ST_SERVE;
                            frame_cnt_d = SERVE_LOAD;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q - 6'd1;
                    end
                end else begin
                    frame_cnt_d = frame_cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output values for the next cycle, derived from the state being entered
    always_comb begin
        run_d        = (state_d == ST_PLAY);
        flash_d      = (state_d == ST_MISS);
        game_over_d  = (state_d == ST_OVER);
        // every transition into SERVE is a (re)serve
        serve_load_d = (state_d == ST_SERVE) && (state_q != ST_SERVE);
        entry_d      = (state_d != state_q);
    end

    bcd_score u_bcd_score (
        .clk25 (clk25),
        .rst_n (rst_n),
        .clr   (score_clr_s),
        .inc   (score_inc_s),
        .score (score)
    );

    assign run        = run_q;
    assign serve_load = serve_load_q;
    assign flash      = flash_q;
    assign game_over  = game_over_q;
    assign lives      = lives_q;
    assign speed      = speed_q;

endmodule

// File: tb/tb_game_sequencer.sv
// ----------------------------------------------------------------------------
// tb_game_sequencer
// Directed bench for game_sequencer with default parameters (3 lives,
// 60 serve frames, 63 miss frames). frame_tick is pulsed every 8 cycles to
// keep the run short.
// ----------------------------------------------------------------------------
module tb_game_sequencer;

    logic       clk25;
    logic       rst_n;
    logic       frame_tick;
    logic       start;
    logic       hit;
    logic       miss;
    logic       run;
    logic       serve_load;
    logic       flash;
    logic       game_over;
    logic [1:0] lives;
    logic [7:0] score;
    logic [1:0] speed;

    int total = 0;
    int bad   = 0;
    int sl_cnt = 0;
    int sl_base;

    game_sequencer dut (
        .clk25      (clk25),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .start      (start),
        .hit        (hit),
        .miss       (miss),
        .run        (run),
        .serve_load (serve_load),
        .flash      (flash),
        .game_over  (game_over),
        .lives      (lives),
        .score      (score),
        .speed      (speed)
    );

    initial clk25 = 1'b0;
    always #20 clk25 = ~clk25;

    // count serve_load pulses, sampled mid-cycle
    always @(negedge clk25) begin
        if (serve_load === 1'b1) sl_cnt <= sl_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk25);
            #1;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(7);
            frame_tick = 1'b1;
            cyc(1);
            frame_tick = 1'b0;
        end
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) begin
            hit = 1'b1;
            cyc(1);
            hit = 1'b0;
            cyc(1);
        end
    endtask

    task automatic press_start();
        start = 1'b1;
        cyc(10);
        start = 1'b0;
        cyc(3);
    endtask

    // hit, miss and start pulses that must be ignored in SERVE and MISS
    task automatic junk_inputs();
        hit = 1'b1;
        cyc(1);
        hit = 1'b0;
        miss = 1'b1;
        cyc(1);
        miss = 1'b0;
        press_start();
    endtask

    initial begin
        rst_n = 1'b0; frame_tick = 1'b0; start = 1'b0; hit = 1'b0; miss = 1'b0;
        cyc(3);
        chk("rst_run", run, 1'b0);
        chk("rst_serve_load", serve_load, 1'b0);
        chk("rst_flash", flash, 1'b0);
        chk("rst_game_over", game_over, 1'b0);
        chk("rst_lives", lives, 2'd0);
        chk("rst_score", score, 8'h00);
        chk("rst_speed", speed, 2'd1);
        rst_n = 1'b1;
        cyc(2);

        // game start: one serve_load, full reload
        sl_base = sl_cnt;
        press_start();
        chk("start_sl_once", sl_cnt - sl_base, 1);
        chk("start_lives", lives, 2'd3);
        chk("start_score", score, 8'h00);
        chk("start_speed", speed, 2'd1);
        chk("start_run", run, 1'b0);

        // SERVE: junk ignored, run rises on the 60th frame
        ticks(30);
        junk_inputs();
        chk("serve_junk_lives", lives, 2'd3);
        chk("serve_junk_score", score, 8'h00);
        chk("serve_junk_run", run, 1'b0);
        chk("serve_junk_sl", sl_cnt - sl_base, 1);
        ticks(29);
        chk("serve_59_run", run, 1'b0);
        ticks(1);
        chk("serve_60_run", run, 1'b1);

        // PLAY: score and speed
        hits(8);
        chk("h8_score", score, 8'h08);
        chk("h8_speed", speed, 2'd2);
        hits(16);
        chk("h24_score", score, 8'h24);
        chk("h24_speed", speed, 2'd3);

        // hit and miss together: miss wins
        hit = 1'b1; miss = 1'b1;
        cyc(1);
        hit = 1'b0; miss = 1'b0;
        chk("hm_score", score, 8'h24);
        chk("hm_lives", lives, 2'd2);
        chk("hm_flash", flash, 1'b1);
        chk("hm_run", run, 1'b0);

        // MISS: junk ignored, 63 frames of flash then reserve
        sl_base = sl_cnt;
        ticks(20);
        junk_inputs();
        chk("miss_junk_lives", lives, 2'd2);
        chk("miss_junk_score", score, 8'h24);
        chk("miss_junk_flash", flash, 1'b1);
        ticks(42);
        chk("miss_62_flash", flash, 1'b1);
        chk("miss_62_sl", sl_cnt - sl_base, 0);
        ticks(1);
        chk("miss_63_flash", flash, 1'b0);
        chk("miss_63_sl", serve_load, 1'b1);
        chk("miss_speed_kept", speed, 2'd3);
        ticks(60);
        chk("reserve_run", run, 1'b1);

        // saturate at 99 (100 hits total)
        hits(76);
        chk("h100_score", score, 8'h99);
        chk("h100_speed", speed, 2'd3);

        // second and third miss -> OVER
        miss = 1'b1; cyc(1); miss = 1'b0;
        chk("m2_lives", lives, 2'd1);
        ticks(63);
        ticks(60);
        miss = 1'b1; cyc(1); miss = 1'b0;
        chk("m3_lives", lives, 2'd0);
        sl_base = sl_cnt;
        ticks(63);
        chk("over_game_over", game_over, 1'b1);
        chk("over_lives", lives, 2'd0);
        chk("over_run", run, 1'b0);
        chk("over_score", score, 8'h99);
        chk("over_sl", sl_cnt - sl_base, 0);

        // restart from OVER; frame_tick held across transition and entry cycles
        sl_base = sl_cnt;
        start = 1'b1;
        cyc(2);
        frame_tick = 1'b1;
        cyc(2);
        frame_tick = 1'b0;
        cyc(8);
        start = 1'b0;
        chk("restart_sl", sl_cnt - sl_base, 1);
        chk("restart_lives", lives, 2'd3);
        chk("restart_score", score, 8'h00);
        chk("restart_speed", speed, 2'd1);
        chk("restart_game_over", game_over, 1'b0);
        ticks(59);
        chk("entry_59_run", run, 1'b0);
        ticks(1);
        chk("entry_60_run", run, 1'b1);

        // reset in PLAY with start held high
        start = 1'b1;
        cyc(3);
        rst_n = 1'b0;
        cyc(2);
        sl_base = sl_cnt;
        rst_n = 1'b1;
        cyc(12);
        chk("rst2_run", run, 1'b0);
        chk("rst2_lives", lives, 2'd0);
        chk("rst2_score", score, 8'h00);
        chk("rst2_speed", speed, 2'd1);
        chk("rst2_no_rise", sl_cnt - sl_base, 0);
        start = 1'b0;
        cyc(5);
        press_start();
        chk("rst2_new_rise", sl_cnt - sl_base, 1);
        chk("rst2_new_lives", lives, 2'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter LIVES, default 3: lives loaded at game start, range 1..3.
REQ-002 Parameter SERVE_FRAMES, default 60: frames the ball is held before play, range 1..63.
REQ-003 Parameter MISS_FRAMES, default 63: frames of miss flash, range 1..63.
REQ-004 clk25  input  1  single 25 MHz pixel clock; all logic is on its rising edge.
REQ-005 Reset  input  1  synchronous, active-low reset.
REQ-006 frame_tick  input  1  one-cycle pulse per frame (end of visible area).
REQ-007 start  input  1  asynchronous push-button, active-high.
REQ-008 hit  input  1  one-cycle pulse on a paddle bounce.
REQ-009 miss  input  1  one-cycle pulse when the ball reaches the bottom wall.
REQ-010 run  output  1  high = ball-motion enable.
REQ-011 serve_load  output  1  one-cycle pulse; ball logic reloads its start position and direction.
REQ-012 flash  output  1  high = miss colour override.
REQ-013 game_over  output  1  high in OVER state.
REQ-014 lives  output  2  remaining lives.
REQ-015 score  output  8  two BCD digits, tens in [7:4].
REQ-016 speed  output  2  ball step size, 1..3.

Function
REQ-017 All outputs SHALL be registered; each output responds one cycle after the qualifying input edge.
REQ-018 start SHALL pass through a 2-flop synchronizer and a rising-edge detector; only the detected edge (start_rise) is used.
REQ-019 States SHALL be IDLE, SERVE, PLAY, MISS, OVER.
REQ-020 IDLE: run=0. On start_rise -> SERVE; load lives=LIVES, score=00, speed=1, hit_cnt=0, frame_cnt=SERVE_FRAMES; pulse serve_load.
REQ-021 SERVE: run=0. frame_cnt decrements on each frame_tick. When frame_tick arrives with frame_cnt==1 -> PLAY.
REQ-022 PLAY: run=1. On hit: score increments in BCD (09->10), saturating at 99. hit_cnt (3-bit) increments; on a wrap from 7 to 0, speed increments, saturating at 3.
REQ-023 PLAY, on miss: lives decrements, frame_cnt=MISS_FRAMES, next state MISS; run drops the next cycle.
REQ-024 hit and miss in the same cycle: miss wins; score and hit_cnt are unchanged.
REQ-025 MISS: flash=1, run=0. frame_cnt decrements on each frame_tick. At expiry: if lives==0 -> OVER; otherwise -> SERVE with frame_cnt=SERVE_FRAMES and a serve_load pulse. speed is retained.
REQ-026 OVER: game_over=1, run=0; score and lives are held. start_rise behaves as in IDLE (full reload, then SERVE).
REQ-027 start_rise SHALL be ignored in SERVE, PLAY and MISS. hit and miss SHALL be ignored outside PLAY.
REQ-028 A frame_tick coincident with a state-entry cycle SHALL NOT count toward the new state's timer.
REQ-029 lives SHALL never underflow; miss with lives==0 cannot occur because of REQ-025.

Reset
REQ-030 Reset low at a clk25 edge: state=IDLE, run=0, serve_load=0, flash=0, game_over=0, lives=0, score=00, speed=1, hit_cnt=0, frame_cnt=0, synchronizer flops=0.
REQ-031 Reset mid-game SHALL abandon the game with no serve_load pulse. A start held high through reset release SHALL NOT produce start_rise.

Structure
REQ-032 State encodings, LIVES, SERVE_FRAMES, MISS_FRAMES defaults and the score width SHALL live in the shared package game_pkg, also used by game and the display logic.
REQ-033 The two-digit saturating BCD counter SHALL be the sub-module bcd_score (inc, clr -> 8-bit BCD out).
REQ-034 Target size is 150-300 lines of RTL, with no clock-domain crossings other than start.

Verification
REQ-035 Reset, start pulse 10 cycles wide, frame_tick every 800 cycles -> exactly one serve_load pulse; run rises 60 frames later; lives=3, score=00, speed=1.
REQ-036 In PLAY, 8 hits -> score=08, speed=2; 16 more -> score=24, speed=3; 100 total -> score=99, speed=3.
REQ-037 hit and miss asserted in the same PLAY cycle -> score unchanged, lives 3->2, flash=1 for 63 frames, then serve_load and SERVE.
REQ-038 Three misses -> game_over=1, lives=0, run=0; start_rise -> lives=3, score=00, SERVE.
REQ-039 Reset asserted in PLAY with start held high -> IDLE, all outputs at reset values, no start_rise until start falls and rises again.
REQ-040 start, hit or miss pulsed in SERVE and MISS -> no state, score or lives change.
